// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: segment vector
// type, bit positions, hex glyph table and the all-off pattern.
package seg7_pkg;

  typedef logic [7:0] seg7_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Every glyph segment (a..g) but not the decimal point.
  localparam seg7_t SEG_GLYPH_MASK = seg7_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                             (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                             (1 << SEG_G));

  localparam seg7_t BLANK = 8'h00;

  // Active-high hex glyphs, bit 0 = segment a, bit 6 = segment g.
  localparam seg7_t SEG7_HEX [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-glyph decoder; the dp input lands on bit 7.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg7_t      seg
);

  // Look up the glyph and overlay the decimal point.
  always_comb begin
    seg         = SEG7_HEX[nibble];
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double
// buffering, leading-zero blanking, per-digit decimal points and PWM
// brightness with a dead cycle at the start of every digit slot.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int SLOT_CYCLES      = 1024,
  parameter int BRIGHT_W         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  output logic                  wr_ready,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            segments,
  output logic                  frame_start
);

  localparam int SLOT_W      = $clog2(SLOT_CYCLES);
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PHASE_SHIFT = SLOT_W - BRIGHT_W;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  DIG_LAST  = IDX_W'(DIGITS - 1);

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic                commit;

  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;

  logic [DIGITS-1:0]   upper_zero;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   dig_onehot;
  logic [BRIGHT_W-1:0] phase;
  logic                lit;
  seg7_t               glyph;
  seg7_t               seg_next;
  logic [DIGITS-1:0]   an_next;

  // Start of digit 0's slot is where a pending write may be committed.
  assign commit   = (slot_cnt == '0) && (dig_idx == '0);
  assign wr_ready = !pend_valid;

  // Slot counter and digit index: the index advances each time a slot wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Double buffer: commit only at a frame boundary so a frame never tears;
  // a full pending buffer refuses further writes instead of overwriting.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data   <= '0;
      act_dp     <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (commit && pend_valid) begin
      act_data   <= pend_data;
      act_dp     <= pend_dp;
      pend_valid <= 1'b0;
    end else if (wr_en && !pend_valid) begin
      pend_data  <= wr_data;
      pend_dp    <= wr_dp;
      pend_valid <= 1'b1;
    end
  end

  // Mark digits whose nibble and every nibble above it are zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run && (act_data[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_run;
    end
  end

  // Pick out the nibble, dp and blanking status of the digit being scanned.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    dig_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_idx == IDX_W'(k)) begin
        cur_nib       = act_data[4*k +: 4];
        cur_dp        = act_dp[k];
        cur_blank     = upper_zero[k] && (k != 0);
        dig_onehot[k] = 1'b1;
      end
    end
  end

  seg7_hex_decoder u_decoder (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (glyph)
  );

  // Brightness gate plus blanking; slot cycle 0 is always dark.
  always_comb begin
    phase    = BRIGHT_W'(slot_cnt >> PHASE_SHIFT);
    lit      = (slot_cnt != '0) && (phase <= bright);
    an_next  = lit ? dig_onehot : '0;
    seg_next = (blank_lz && cur_blank) ? (glyph & ~SEG_GLYPH_MASK) : glyph;
  end

  // Output registers, with polarity applied on the way out.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes      <= ANODE_ACTIVE_LOW ? '1 : '0;
      segments    <= SEG_ACTIVE_LOW ? ~BLANK : BLANK;
      frame_start <= 1'b0;
    end else begin
      anodes      <= ANODE_ACTIVE_LOW ? ~an_next : an_next;
      segments    <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
      frame_start <= commit;
    end
  end

endmodule
